// File: rtl/audio_sample_fifo_if.sv
// Sample bus between the CPU store path / PWM side and the audio sample FIFO.
// Master drives pushes and consumes samples; slave is the FIFO.
interface audio_sample_fifo_if #(
  parameter int unsigned DATA_W = 16
);
  logic              we_i;
  logic [31:0]       wdata_i;
  logic [DATA_W-1:0] sample_o;
  logic              sample_stb_o;

  modport master (
    output we_i,
    output wdata_i,
    input  sample_o,
    input  sample_stb_o
  );

  modport slave (
    input  we_i,
    input  wdata_i,
    output sample_o,
    output sample_stb_o
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// PCM sample FIFO with a sample-rate pacer: one head entry is released to the PWM
// per CLK_DIV clocks, with level, sticky overflow/underflow and low-watermark irq.
module audio_sample_fifo #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CLK_DIV = 2268,
  parameter int unsigned LOW_WM  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic                       clr_flags_i,
  audio_sample_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic                       irq_o
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned DivW = $clog2(CLK_DIV);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              stb_q, stb_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic tick, pop, push_ok, full, empty;
  logic unused_wdata;

  assign unused_wdata = ^bus.wdata_i[31:DATA_W];

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign tick  = enable_i && (div_q == DivW'(CLK_DIV - 1));
  assign pop   = tick && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = bus.we_i && (!full || pop);

  always_comb begin
    div_d    = div_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    sample_d = sample_q;
    stb_d    = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (!enable_i || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d   = rptr_q + 1'b1;
      sample_d = mem_q[rptr_q];
      stb_d    = 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Clear first so that a same-cycle set wins.
    if (clr_flags_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.we_i && full && !pop) begin
      ovf_d = 1'b1;
    end
    if (tick && empty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      sample_q <= '0;
      stb_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      sample_q <= sample_d;
      stb_q    <= stb_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= bus.wdata_i[DATA_W-1:0];
    end
  end

  assign bus.sample_o     = sample_q;
  assign bus.sample_stb_o = stb_q;
  assign level_o          = level_q;
  assign empty_o          = empty;
  assign full_o           = full;
  assign overflow_o       = ovf_q;
  assign underflow_o      = unf_q;
  assign irq_o            = (level_q <= LW'(LOW_WM));
endmodule
